job_nonce_link: RTL and testbench

JOB_NONCE_LINK -- requirements
Module: job_nonce_link

---
 rtl/job_nonce_link.sv | 159 +++++++++++++++
 tb/tb_job_nonce_link.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/job_nonce_link.sv
// Job/nonce link: streams a latched job word byte-by-byte into the miner's job shift
// register, and collects a nonce from the nonce shift register whenever the miner reports one.
module job_nonce_link #(
    parameter int JOB_BYTES   = 80,
    parameter int NONCE_BYTES = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [8*JOB_BYTES-1:0]   job_in,
    input  logic                     job_valid,
    output logic                     job_ready,
    output logic [7:0]               sr_data,
    output logic                     sr_shift,
    output logic                     job_loaded,
    input  logic                     found,
    output logic                     nonce_load,
    output logic                     nonce_en,
    input  logic [7:0]               nonce_byte,
    output logic [8*NONCE_BYTES-1:0] nonce_out,
    output logic                     nonce_valid,
    input  logic                     nonce_ack
);

    localparam int JW  = 8 * JOB_BYTES;
    localparam int NW  = 8 * NONCE_BYTES;
    localparam int BW  = $clog2(JOB_BYTES + 1);
    localparam int NBW = $clog2(NONCE_BYTES + 1);
    localparam logic [BW-1:0]  BLAST = BW'(JOB_BYTES - 1);
    localparam logic [NBW-1:0] NLAST = NBW'(NONCE_BYTES - 1);

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        LOADN,
        READN,
        DRAIN,
        HOLD
    } state_t;

    state_t          state;
    state_t          next;
    logic            pend;
    logic [BW-1:0]   bcnt;
    logic [NBW-1:0]  ncnt;
    logic [JW-1:0]   jreg;
    logic [NW-1:0]   nacc;
    logic [NW-1:0]   nacc_shift;
    logic            en_d;
    logic            job_fire;

    assign job_fire   = (state == IDLE) && !pend && job_valid;
    assign nacc_shift = (nacc << 8) | NW'(nonce_byte);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next;
        end
    end

    // A pending nonce always wins over a waiting job, so job_ready is held low while pend is set.
    always_comb begin
        next        = state;
        job_ready   = 1'b0;
        sr_shift    = 1'b0;
        sr_data     = 8'h00;
        nonce_load  = 1'b0;
        nonce_en    = 1'b0;
        nonce_valid = 1'b0;
        case (state)
            IDLE: begin
                job_ready = !pend;
                if (pend) begin
                    next = LOADN;
                end else if (job_valid) begin
                    next = SEND;
                end
            end
            SEND: begin
                sr_shift = 1'b1;
                sr_data  = jreg[JW-1 -: 8];
                if (bcnt == BLAST) begin
                    next = IDLE;
                end
            end
            LOADN: begin
                nonce_load = 1'b1;
                next       = READN;
            end
            READN: begin
                nonce_en = 1'b1;
                if (ncnt == NLAST) begin
                    next = DRAIN;
                end
            end
            DRAIN: begin
                next = HOLD;
            end
            HOLD: begin
                nonce_valid = 1'b1;
                if (nonce_ack) begin
                    next = IDLE;
                end
            end
            default: begin
                next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend       <= 1'b0;
            bcnt       <= '0;
            jreg       <= '0;
            job_loaded <= 1'b0;
        end else begin
            if (found) begin
                pend <= 1'b1;
            end else if (state == LOADN) begin
                pend <= 1'b0;
            end
            job_loaded <= (state == SEND) && (bcnt == BLAST);
            if (job_fire) begin
                jreg <= job_in;
                bcnt <= '0;
            end else if (state == SEND) begin
                jreg <= jreg << 8;
                bcnt <= bcnt + BW'(1);
            end
        end
    end

    // The shift register answers one cycle after each nonce_en, so capture runs one cycle
    // behind the enable and the final byte lands in DRAIN together with the output load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ncnt      <= '0;
            en_d      <= 1'b0;
            nacc      <= '0;
            nonce_out <= '0;
        end else begin
            en_d <= nonce_en;
            if (state == LOADN) begin
                ncnt <= '0;
            end else if (state == READN) begin
                ncnt <= ncnt + NBW'(1);
            end
            if (en_d) begin
                nacc <= nacc_shift;
            end
            if (state == DRAIN) begin
                nonce_out <= nacc_shift;
            end
        end
    end

endmodule

// File: tb/tb_job_nonce_link.sv
// Directed bench for job_nonce_link: job streaming, nonce collection, priority, hold and reset abort.
module tb_job_nonce_link;

    localparam int JB = 80;
    localparam int NB = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [8*JB-1:0]   job_in;
    logic              job_valid;
    logic              job_ready;
    logic [7:0]        sr_data;
    logic              sr_shift;
    logic              job_loaded;
    logic              found;
    logic              nonce_load;
    logic              nonce_en;
    logic [7:0]        nonce_byte = 8'h00;
    logic [8*NB-1:0]   nonce_out;
    logic              nonce_valid;
    logic              nonce_ack;

    logic [8*JB-1:0]   job;
    logic [63:0]       nonce_src;
    logic [63:0]       nsr = 64'h0;
    int                n_checks = 0;
    int                n_fail   = 0;

    localparam logic [63:0] NA = 64'hDEADBEEF_01234567;
    localparam logic [63:0] NBV = 64'h00112233_44556677;

    job_nonce_link #(.JOB_BYTES(JB), .NONCE_BYTES(NB)) dut (
        .clk         (clk),
        .rst         (rst),
        .job_in      (job_in),
        .job_valid   (job_valid),
        .job_ready   (job_ready),
        .sr_data     (sr_data),
        .sr_shift    (sr_shift),
        .job_loaded  (job_loaded),
        .found       (found),
        .nonce_load  (nonce_load),
        .nonce_en    (nonce_en),
        .nonce_byte  (nonce_byte),
        .nonce_out   (nonce_out),
        .nonce_valid (nonce_valid),
        .nonce_ack   (nonce_ack)
    );

    always #5 clk = ~clk;

    // Model of the miner's nonce shift register: byte appears one cycle after each enable.
    always @(posedge clk) begin
        if (nonce_load) begin
            nsr <= nonce_src;
        end else if (nonce_en) begin
            nonce_byte <= nsr[63:56];
            nsr        <= nsr << 8;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_job(input int found_at);
        job_in    = job;
        job_valid = 1'b1;
        tick;
        job_valid = 1'b0;
        for (int i = 1; i <= JB; i++) begin
            n_checks++;
            if (sr_shift !== 1'b1 || sr_data !== 8'(i) || job_ready !== 1'b0 || job_loaded !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL send_byte%0d: shift=%b data=%h ready=%b loaded=%b, want 1 %h 0 0",
                         i, sr_shift, sr_data, job_ready, job_loaded, 8'(i));
            end
            found = (i == found_at);
            tick;
        end
        found = 1'b0;
        n_checks++;
        if (job_loaded !== 1'b1 || sr_shift !== 1'b0 || sr_data !== 8'h00 ||
            job_ready !== (found_at < 0)) begin
            n_fail++;
            $display("[TB] FAIL job_done: loaded=%b shift=%b data=%h ready=%b, want 1 0 00 %b",
                     job_loaded, sr_shift, sr_data, job_ready, found_at < 0);
        end
    endtask

    task automatic read_nonce(input logic [63:0] exp);
        int  loads = 0;
        int  ens = 0;
        int  overlap = 0;
        int  busy = 0;
        int  cycles = 0;
        bit  seen = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            tick;
            cycles++;
            if (nonce_load) loads++;
            if (nonce_en) ens++;
            if (nonce_load && nonce_en) overlap++;
            if (job_ready || sr_shift) busy++;
            if (nonce_valid) seen = 1'b1;
        end
        n_checks++;
        if (!seen || cycles != 11) begin
            n_fail++;
            $display("[TB] FAIL read_latency: seen=%b cycles=%0d, want 1 11", seen, cycles);
        end
        n_checks++;
        if (loads != 1) begin
            n_fail++;
            $display("[TB] FAIL load_count: got %0d, want 1", loads);
        end
        n_checks++;
        if (ens != NB) begin
            n_fail++;
            $display("[TB] FAIL en_count: got %0d, want %0d", ens, NB);
        end
        n_checks++;
        if (overlap != 0 || busy != 0) begin
            n_fail++;
            $display("[TB] FAIL read_excl: overlap=%0d busy=%0d, want 0 0", overlap, busy);
        end
        n_checks++;
        if (nonce_out !== exp) begin
            n_fail++;
            $display("[TB] FAIL nonce_value: got %h, want %h", nonce_out, exp);
        end
    endtask

    task automatic do_ack(input logic [63:0] exp);
        nonce_ack = 1'b1;
        tick;
        nonce_ack = 1'b0;
        n_checks++;
        if (nonce_valid !== 1'b0 || nonce_out !== exp) begin
            n_fail++;
            $display("[TB] FAIL ack: valid=%b out=%h, want 0 %h", nonce_valid, nonce_out, exp);
        end
    endtask

    task automatic pulse_found;
        found = 1'b1;
        tick;
        found = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick;
        tick;
        n_checks++;
        if (job_ready !== 1'b1 || sr_shift !== 1'b0 || sr_data !== 8'h00 || job_loaded !== 1'b0 ||
            nonce_load !== 1'b0 || nonce_en !== 1'b0 || nonce_valid !== 1'b0 || nonce_out !== 64'h0) begin
            n_fail++;
            $display("[TB] FAIL reset_held: ready=%b shift=%b data=%h loaded=%b load=%b en=%b valid=%b out=%h",
                     job_ready, sr_shift, sr_data, job_loaded, nonce_load, nonce_en, nonce_valid, nonce_out);
        end
        rst = 1'b0;
        tick;
        n_checks++;
        if (job_ready !== 1'b1 || sr_shift !== 1'b0 || job_loaded !== 1'b0 ||
            nonce_load !== 1'b0 || nonce_valid !== 1'b0 || nonce_out !== 64'h0) begin
            n_fail++;
            $display("[TB] FAIL reset_release: ready=%b shift=%b loaded=%b load=%b valid=%b out=%h",
                     job_ready, sr_shift, job_loaded, nonce_load, nonce_valid, nonce_out);
        end
    endtask

    task automatic test_basic_job;
        drive_job(-1);
        tick;
    endtask

    task automatic test_nonce_read;
        nonce_src = NA;
        pulse_found;
        read_nonce(NA);
        do_ack(NA);
    endtask

    task automatic test_found_in_send;
        nonce_src = NA;
        drive_job(40);
        read_nonce(NA);
        do_ack(NA);
    endtask

    task automatic test_priority;
        int  waited = 0;
        bit  seen = 1'b0;
        nonce_src = NA;
        pulse_found;
        job_in    = job;
        job_valid = 1'b1;
        n_checks++;
        if (job_ready !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL prio_ready: got %b, want 0", job_ready);
        end
        read_nonce(NA);
        do_ack(NA);
        n_checks++;
        if (job_ready !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL prio_ready_after_ack: got %b, want 1", job_ready);
        end
        tick;
        job_valid = 1'b0;
        n_checks++;
        if (sr_shift !== 1'b1 || sr_data !== 8'h01) begin
            n_fail++;
            $display("[TB] FAIL prio_job_start: shift=%b data=%h, want 1 01", sr_shift, sr_data);
        end
        for (int c = 0; c < 100 && !seen; c++) begin
            tick;
            waited++;
            if (job_loaded) seen = 1'b1;
        end
        n_checks++;
        if (!seen || waited != JB) begin
            n_fail++;
            $display("[TB] FAIL prio_job_done: seen=%b cycles=%0d, want 1 %0d", seen, waited, JB);
        end
    endtask

    task automatic test_hold;
        int unstable = 0;
        nonce_src = NA;
        pulse_found;
        read_nonce(NA);
        for (int i = 0; i < 20; i++) begin
            found = (i == 5);
            tick;
            if (nonce_valid !== 1'b1 || nonce_out !== NA) unstable++;
        end
        found = 1'b0;
        n_checks++;
        if (unstable != 0) begin
            n_fail++;
            $display("[TB] FAIL hold_stable: unstable cycles %0d, want 0", unstable);
        end
        nonce_src = NBV;
        do_ack(NA);
        read_nonce(NBV);
        do_ack(NBV);
    endtask

    task automatic test_ack_ignored;
        nonce_ack = 1'b1;
        tick;
        nonce_ack = 1'b0;
        n_checks++;
        if (job_ready !== 1'b1 || nonce_valid !== 1'b0 || nonce_out !== NBV) begin
            n_fail++;
            $display("[TB] FAIL ack_idle: ready=%b valid=%b out=%h, want 1 0 %h",
                     job_ready, nonce_valid, nonce_out, NBV);
        end
        nonce_src = NA;
        pulse_found;
        nonce_ack = 1'b1;
        read_nonce(NA);
        do_ack(NA);
    endtask

    task automatic test_reset_abort;
        int ghost = 0;
        job_in    = job;
        job_valid = 1'b1;
        tick;
        job_valid = 1'b0;
        repeat (9) tick;
        n_checks++;
        if (sr_data !== 8'h0a) begin
            n_fail++;
            $display("[TB] FAIL abort_pos: data=%h, want 0a", sr_data);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (sr_shift !== 1'b0 || sr_data !== 8'h00 || job_loaded !== 1'b0 ||
            nonce_valid !== 1'b0 || nonce_out !== 64'h0 || nonce_en !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL abort_send: shift=%b data=%h loaded=%b valid=%b out=%h en=%b, want all 0",
                     sr_shift, sr_data, job_loaded, nonce_valid, nonce_out, nonce_en);
        end
        tick;
        rst = 1'b0;
        for (int c = 0; c < JB + 5; c++) begin
            tick;
            if (job_loaded || sr_shift) ghost++;
        end
        n_checks++;
        if (ghost != 0) begin
            n_fail++;
            $display("[TB] FAIL abort_ghost: loaded/shift cycles %0d, want 0", ghost);
        end
        drive_job(-1);
        tick;
        nonce_src = NA;
        pulse_found;
        repeat (5) tick;
        rst = 1'b1;
        #1;
        n_checks++;
        if (nonce_en !== 1'b0 || nonce_valid !== 1'b0 || nonce_out !== 64'h0) begin
            n_fail++;
            $display("[TB] FAIL abort_read: en=%b valid=%b out=%h, want 0 0 0", nonce_en, nonce_valid, nonce_out);
        end
        tick;
        rst = 1'b0;
        ghost = 0;
        for (int c = 0; c < 20; c++) begin
            tick;
            if (nonce_valid || nonce_load || nonce_en) ghost++;
        end
        n_checks++;
        if (ghost != 0) begin
            n_fail++;
            $display("[TB] FAIL abort_read_ghost: active cycles %0d, want 0", ghost);
        end
    endtask

    initial begin
        rst       = 1'b1;
        job_in    = '0;
        job_valid = 1'b0;
        found     = 1'b0;
        nonce_ack = 1'b0;
        nonce_src = NA;
        job       = '0;
        for (int b = 0; b < JB; b++) begin
            job[8*JB-1-8*b -: 8] = 8'(b + 1);
        end
        test_reset;
        test_basic_job;
        test_nonce_read;
        test_found_in_send;
        test_priority;
        test_hold;
        test_ack_ignored;
        test_reset_abort;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish, failures so far %0d", n_fail);
        $fatal(1);
    end

endmodule
